header_loader: RTL

Upstream work-intake stage of the bitcoin miner. Receives one 80-byte block header as a 20-beat 32-bit AXI-Stream packet and converts header fields from little-endian wire order to SHA-256 word order. Presents the result as a parallel work item (first 512-bit message block, 96-bit tail, starting nonce) to the AXI-Stream hashing wrapper / `sha_top` through a valid/ready handshake. Malformed packets (wrong length) are discarded and counted.

---
 rtl/miner_pkg.sv | 20 ++
 rtl/header_loader_if.sv | 23 ++
 rtl/header_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared miner definitions: header geometry, intake FSM states and the
// word byte-reversal helper used to move header words into SHA-256 word order.
package miner_pkg;

   localparam int HDR_WORDS  = 20;
   localparam int BLK_WORDS  = 16;
   localparam int TAIL_WORDS = 3;
   localparam int NONCE_IDX  = 19;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } hl_state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/header_loader_if.sv
// Bundles for the header intake stream and the parallel work-item handoff.
interface axis32_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        tready;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

interface work_if;
   logic         work_valid;
   logic         work_ready;
   logic [511:0] prev_blk;
   logic [95:0]  input_M;
   logic [31:0]  nonce_start;

   modport master (output work_valid, output prev_blk, output input_M,
                   output nonce_start, input work_ready);
   modport slave  (input  work_valid, input  prev_blk, input  input_M,
                   input  nonce_start, output work_ready);
endinterface

// File: rtl/header_loader.sv
// Collects a 20-beat header packet into a register array, byte-reverses each
// word and presents the header as one parallel work item; bad-length packets are dropped.
module header_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int HDR_WORDS  = 20,
   parameter int BYTE_SWAP  = 1
) (
   input  logic        clk,
   input  logic        reset,
   axis32_if.slave     s_axis,
   work_if.master      work,
   output logic        err_len,
   output logic [7:0]  err_cnt
);
   import miner_pkg::*;

   localparam int PTR_W = $clog2(HDR_WORDS);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(HDR_WORDS - 1);

   hl_state_t             state_q, state_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] hdr_q [HDR_WORDS];
   logic [DATA_WIDTH-1:0] hdr_d [HDR_WORDS];
   logic                  err_len_q, err_len_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic [DATA_WIDTH-1:0] word_in;
   logic                  beat_acc;
   logic                  fill_beat;
   logic                  at_last;

   assign beat_acc  = s_axis.tvalid && s_axis.tready;
   assign fill_beat = beat_acc && (state_q == FILL);
   assign at_last   = (wr_ptr_q == LAST_PTR);
   assign word_in   = (BYTE_SWAP != 0) ? bswap32(s_axis.tdata) : s_axis.tdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: begin
            if (fill_beat && at_last) begin
               state_d = s_axis.tlast ? HOLD : DRAIN;
            end
         end
         DRAIN: begin
            if (beat_acc && s_axis.tlast) begin
               state_d = FILL;
            end
         end
         HOLD: begin
            if (work.work_ready) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Ready is gated by reset so no beat is taken while the block is being cleared.
   always_comb begin
      s_axis.tready   = !reset && (state_q != HOLD);
      work.work_valid = (state_q == HOLD);
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      hdr_d     = hdr_q;
      err_len_d = 1'b0;
      err_cnt_d = err_cnt_q;
      if (fill_beat) begin
         hdr_d[wr_ptr_q] = word_in;
         wr_ptr_d        = (s_axis.tlast || at_last) ? '0 : wr_ptr_q + 1'b1;
         err_len_d       = (s_axis.tlast != at_last);
      end
      if (err_len_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         err_len_q <= 1'b0;
         err_cnt_q <= '0;
         for (int i = 0; i < HDR_WORDS; i++) begin
            hdr_q[i] <= '0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         err_len_q <= err_len_d;
         err_cnt_q <= err_cnt_d;
         hdr_q     <= hdr_d;
      end
   end

   assign err_len = err_len_q;
   assign err_cnt = err_cnt_q;

   // Word 0 lands in the most significant slot of each output vector.
   genvar gi;
   generate
      for (gi = 0; gi < BLK_WORDS; gi++) begin : g_blk
         assign work.prev_blk[511 - DATA_WIDTH*gi -: DATA_WIDTH] = hdr_q[gi];
      end
      for (gi = 0; gi < TAIL_WORDS; gi++) begin : g_tail
         assign work.input_M[95 - DATA_WIDTH*gi -: DATA_WIDTH] = hdr_q[BLK_WORDS + gi];
      end
   endgenerate

   assign work.nonce_start = hdr_q[NONCE_IDX];

endmodule
